// File: rtl/cmp_seq_pkg.sv
// ============================================================================
// Module  : cmp_seq_pkg
// Brief   : Shared types and default timing for the comparator sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    NOVL1     = 3'd2,
    PH1       = 3'd3,
    NOVL2     = 3'd4,
    PH2       = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam int DEF_CNT_W         = 6;
  localparam int DEF_ACC_W         = 8;
  localparam int DEF_PRECHARGE_CYC = 7;
  localparam int DEF_PHASE_CYC     = 4;
  localparam int DEF_SAMPLE_OFS    = 1;
  localparam int DEF_NOVL_CYC      = 1;

  // Cycles from the accepting edge until the last run cycle; done follows.
  function automatic int unsigned run_cycles(input int unsigned n,
                                             input int unsigned pre,
                                             input int unsigned ph,
                                             input int unsigned novl);
    return pre + n * 2 * (novl + ph);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_phase_timer.sv
// ============================================================================
// Module  : cmp_phase_timer
// Brief   : Loadable down-counter with expire flag and elapsed-cycle index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o,
  output logic [CNT_W-1:0] idx_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
      idx_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      idx_q <= idx_q + CNT_W'(1);
    end
  end

  assign expire_o = (cnt_q == '0);
  assign idx_o    = idx_q;

endmodule

`default_nettype wire

// File: rtl/cmp_seq_ctrl.sv
// ============================================================================
// Module  : cmp_seq_ctrl
// Brief   : Precharge + N two-phase compare decisions, counts high results.
//           Optional input chopping enabled by macro CMP_SEQ_CHOP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_seq_ctrl
  import cmp_seq_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int PRECHARGE_CYC = DEF_PRECHARGE_CYC,
  parameter int PHASE_CYC     = DEF_PHASE_CYC,
  parameter int SAMPLE_OFS    = DEF_SAMPLE_OFS,
  parameter int NOVL_CYC      = DEF_NOVL_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [ACC_W-1:0] n_conv_i,
  input  logic             cmp_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACC_W-1:0] ones_cnt_o,
  output logic             zero_o,
  output logic             cmp_p1_o,
  output logic             cmp_p2_o,
  output logic             sample_o,
  output logic             chop_o
);

  localparam logic [CNT_W-1:0] LD_PRE  = CNT_W'(PRECHARGE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PH   = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_NOVL = CNT_W'((NOVL_CYC > 0) ? NOVL_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] SMP_IDX = CNT_W'(SAMPLE_OFS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] rem_q;
  logic [ACC_W-1:0] ones_q;
  logic             busy_q, done_q, zero_q, p1_q, p2_q, sample_q;

  logic             tmr_load, tmr_exp;
  logic [CNT_W-1:0] tmr_val, tmr_idx, idx_d;
  logic             start_ok;
  logic             chop_w;

  assign start_ok = (state_q == IDLE) && start_i && !abort_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_ok) state_d = (n_conv_i == '0) ? DONE : PRECHARGE;
      PRECHARGE: if (tmr_exp) state_d = (NOVL_CYC > 0) ? NOVL1 : PH1;
      NOVL1:     if (tmr_exp) state_d = PH1;
      PH1:       if (tmr_exp) state_d = (NOVL_CYC > 0) ? NOVL2 : PH2;
      NOVL2:     if (tmr_exp) state_d = PH2;
      PH2: begin
        if (tmr_exp) begin
          if (rem_q == ACC_W'(1)) state_d = DONE;
          else                    state_d = (NOVL_CYC > 0) ? NOVL1 : PH1;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) state_d = IDLE;
  end

  // Every state change reloads the timer with that state's length minus one.
  always_comb begin
    tmr_val = '0;
    case (state_d)
      PRECHARGE:    tmr_val = LD_PRE;
      NOVL1, NOVL2: tmr_val = LD_NOVL;
      PH1, PH2:     tmr_val = LD_PH;
      default:      tmr_val = '0;
    endcase
  end

  assign tmr_load = (state_d != state_q);
  assign idx_d    = tmr_load ? '0 : tmr_idx + CNT_W'(1);

  cmp_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_exp),
    .idx_o      (tmr_idx)
  );

  // Outputs are decoded from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b1;
      sample_q <= 1'b0;
      rem_q    <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      zero_q   <= (state_d == PRECHARGE);
      p1_q     <= (state_d == PH1);
      p2_q     <= (state_d == IDLE) || (state_d == PRECHARGE) ||
                  (state_d == PH2)  || (state_d == DONE);
      sample_q <= (state_d == PH1) && (idx_d == SMP_IDX);

      if (start_ok)
        rem_q <= n_conv_i;
      else if ((state_q == PH2) && tmr_exp && !abort_i)
        rem_q <= rem_q - ACC_W'(1);

      if (start_ok)
        ones_q <= '0;
      else if (sample_q && (cmp_out_i ^ chop_w))
        ones_q <= ones_q + ACC_W'(1);
    end
  end

`ifdef CMP_SEQ_CHOP_EN
  logic chop_q;
  logic next_dec;

  assign next_dec = (state_q == PH2) && ((state_d == NOVL1) || (state_d == PH1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                chop_q <= 1'b0;
    else if (state_d == IDLE)  chop_q <= 1'b0;
    else if (next_dec)         chop_q <= ~chop_q;
  end

  assign chop_w = chop_q;
`else
  assign chop_w = 1'b0;
`endif

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ones_cnt_o = ones_q;
  assign zero_o     = zero_q;
  assign cmp_p1_o   = p1_q;
  assign cmp_p2_o   = p2_q;
  assign sample_o   = sample_q;
  assign chop_o     = chop_w;

endmodule

`default_nettype wire
